gray_decoder_tracker: RTL and testbench

//   Receive-side companion to the Gray-code counter. Samples a Gray-coded count

---
 rtl/gray_decoder_tracker_if.sv | 26 ++
 rtl/gray_decoder_tracker.sv | 140 ++++++++++++++
 tb/tb_gray_decoder_tracker.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gray_decoder_tracker_if.sv
// Interface between a Gray-coded count source and gray_decoder_tracker.
// The master drives the sample; the slave returns the decode and the tracking flags.
interface gray_decoder_tracker_if #(
    parameter int WIDTH      = 3,
    parameter int WRAP_CNT_W = 4
);
    logic                  En;
    logic [WIDTH-1:0]      GrayIn;
    logic [WIDTH-1:0]      BinOut;
    logic                  OutValid;
    logic                  Dir;
    logic                  StepErr;
    logic                  Error;
    logic                  Overflow;
    logic [WRAP_CNT_W-1:0] WrapCnt;

    modport master (
        output En, GrayIn,
        input  BinOut, OutValid, Dir, StepErr, Error, Overflow, WrapCnt
    );

    modport slave (
        input  En, GrayIn,
        output BinOut, OutValid, Dir, StepErr, Error, Overflow, WrapCnt
    );
endinterface

// File: rtl/gray_decoder_tracker.sv
// Gray-to-binary decoder that checks each step (+1/-1/repeat) and tracks direction and up-wraps.
// 1-cycle latency, no backpressure; optional GRAY_RESYNC_EN makes FAULT relock on the next sample.
module gray_decoder_tracker #(
    parameter int WIDTH      = 3,
    parameter int WRAP_CNT_W = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    gray_decoder_tracker_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]      ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]      MAX_W    = {WIDTH{1'b1}};
    localparam logic [WRAP_CNT_W-1:0] ONE_C    = {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WRAP_CNT_W-1:0] MAX_C    = {WRAP_CNT_W{1'b1}};

    state_t                  r_state;
    logic [WIDTH-1:0]        r_bin;
    logic                    r_vld;
    logic                    r_dir;
    logic                    r_step_err;
    logic                    r_err;
    logic                    r_ovf;
    logic [WRAP_CNT_W-1:0]   r_wrap;

    state_t                  w_state_nxt;
    logic [WIDTH-1:0]        w_bin_nxt;
    logic                    w_vld_nxt;
    logic                    w_dir_nxt;
    logic                    w_step_err_nxt;
    logic                    w_err_nxt;
    logic                    w_ovf_nxt;
    logic [WRAP_CNT_W-1:0]   w_wrap_nxt;

    logic [WIDTH-1:0]        w_dec;
    logic [WIDTH-1:0]        w_inc;
    logic [WIDTH-1:0]        w_dec_prev;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign w_dec[i] = ^bus.GrayIn[WIDTH-1:i];
    end

    assign w_inc      = r_bin + ONE_W;
    assign w_dec_prev = r_bin - ONE_W;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= EMPTY;
            r_bin      <= '0;
            r_vld      <= 1'b0;
            r_dir      <= 1'b0;
            r_step_err <= 1'b0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_wrap     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_bin      <= w_bin_nxt;
            r_vld      <= w_vld_nxt;
            r_dir      <= w_dir_nxt;
            r_step_err <= w_step_err_nxt;
            r_err      <= w_err_nxt;
            r_ovf      <= w_ovf_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bin_nxt      = r_bin;
        w_vld_nxt      = 1'b0;
        w_dir_nxt      = r_dir;
        w_step_err_nxt = 1'b0;
        w_err_nxt      = r_err;
        w_ovf_nxt      = r_ovf;
        w_wrap_nxt     = r_wrap;

        case (r_state)
            EMPTY: begin
                if (bus.En) begin
                    w_bin_nxt   = w_dec;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (bus.En) begin
                    w_bin_nxt = w_dec;
                    w_vld_nxt = 1'b1;
                    if (w_dec == r_bin) begin
                        w_dir_nxt = r_dir;
                    end else if (w_dec == w_inc) begin
                        w_dir_nxt = 1'b1;
                        if (r_bin == MAX_W) begin
                            w_ovf_nxt = 1'b1;
                            if (r_wrap != MAX_C) begin
                                w_wrap_nxt = r_wrap + ONE_C;
                            end
                        end
                    end else if (w_dec == w_dec_prev) begin
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_step_err_nxt = 1'b1;
                        w_err_nxt      = 1'b1;
                        w_state_nxt    = FAULT;
                    end
                end
            end
            FAULT: begin
                if (bus.En) begin
                    w_bin_nxt = w_dec;
                    w_vld_nxt = 1'b1;
`ifdef GRAY_RESYNC_EN
                    // Sample after a fault becomes the new reference, unchecked.
                    w_state_nxt = LOCKED;
`else
                    w_state_nxt = FAULT;
`endif
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    assign bus.BinOut   = r_bin;
    assign bus.OutValid = r_vld;
    assign bus.Dir      = r_dir;
    assign bus.StepErr  = r_step_err;
    assign bus.Error    = r_err;
    assign bus.Overflow = r_ovf;
    assign bus.WrapCnt  = r_wrap;
endmodule

// File: tb/tb_gray_decoder_tracker.sv
// Bench for gray_decoder_tracker: directed scenarios then random steps vs. a behavioural model.
// Honours GRAY_RESYNC_EN for the expected post-fault behaviour.
module tb_gray_decoder_tracker;
    localparam int W  = 3;
    localparam int CW = 4;
    localparam int MODV = 1 << W;
    localparam int CMAX = (1 << CW) - 1;
`ifdef GRAY_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Behavioural model: whether a reference exists, whether checking is suspended,
    // and the expected values of every output.
    bit m_have_ref, m_fault;
    int m_bin, m_vld, m_dir, m_serr, m_err, m_ovf, m_wrap;

    gray_decoder_tracker_if #(.WIDTH(W), .WRAP_CNT_W(CW)) bus ();

    gray_decoder_tracker #(.WIDTH(W), .WRAP_CNT_W(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic int gray2bin(input int g);
        int b = 0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b % MODV;
    endfunction

    function automatic int bin2gray(input int b);
        return (b ^ (b >> 1)) % MODV;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".BinOut"},   int'(bus.BinOut),   m_bin);
        chk({tag, ".OutValid"}, int'(bus.OutValid), m_vld);
        chk({tag, ".Dir"},      int'(bus.Dir),      m_dir);
        chk({tag, ".StepErr"},  int'(bus.StepErr),  m_serr);
        chk({tag, ".Error"},    int'(bus.Error),    m_err);
        chk({tag, ".Overflow"}, int'(bus.Overflow), m_ovf);
        chk({tag, ".WrapCnt"},  int'(bus.WrapCnt),  m_wrap);
    endtask

    task automatic model_reset();
        m_have_ref = 0; m_fault = 0;
        m_bin = 0; m_vld = 0; m_dir = 0; m_serr = 0; m_err = 0; m_ovf = 0; m_wrap = 0;
    endtask

    task automatic model_sample(input bit en, input int g);
        int d, diff;
        m_vld  = en;
        m_serr = 0;
        if (!en) return;
        d = gray2bin(g);
        if (!m_have_ref) begin
            m_have_ref = 1;
        end else if (!m_fault) begin
            diff = (d - m_bin + MODV) % MODV;
            if (diff == 1) begin
                m_dir = 1;
                if (m_bin == MODV - 1) begin
                    m_ovf  = 1;
                    m_wrap = (m_wrap < CMAX) ? m_wrap + 1 : CMAX;
                end
            end else if (diff == MODV - 1) begin
                m_dir = 0;
            end else if (diff != 0) begin
                m_serr = 1;
                m_err  = 1;
                if (RESYNC) m_have_ref = 0;
                else        m_fault = 1;
            end
        end
        m_bin = d;
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        Reset     = 1'b1;
        bus.En    = 1'b1;
        bus.GrayIn = W'($urandom);
        @(posedge Clk);
        model_reset();
        #1 check_all(tag);
    endtask

    task automatic step(input string tag, input bit en, input int g);
        @(negedge Clk);
        Reset      = 1'b0;
        bus.En     = en;
        bus.GrayIn = W'(g);
        @(posedge Clk);
        model_sample(en, g);
        #1 check_all(tag);
    endtask

    int seq1 [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    int seq2 [4] = '{0, 4, 5, 7};

    initial begin
        int r, g;
        Reset      = 1'b1;
        bus.En     = 1'b0;
        bus.GrayIn = '0;
        model_reset();

        do_reset("reset");

        // Full up-count with one wrap
        foreach (seq1[i]) step("up", 1'b1, seq1[i]);

        do_reset("reset2");
        foreach (seq2[i]) step("down", 1'b1, seq2[i]);

        // Illegal 0 -> 2 step, then a further sample
        do_reset("reset3");
        step("err0", 1'b1, 0);
        step("err1", 1'b1, 3);
        step("err2", 1'b1, 2);

        // Repeat and gaps
        do_reset("reset4");
        step("gap0", 1'b1, 1);
        for (int i = 0; i < 3; i++) step("gapidle", 1'b0, 0);
        step("gap1", 1'b1, 1);
        step("gap2", 1'b1, 3);

        // Drive the wrap counter into saturation, then reset mid-stream
        do_reset("reset5");
        for (int c = 0; c < 17; c++)
            for (int b = 0; b < MODV; b++) step("sat", 1'b1, bin2gray(b));
        step("sat_end", 1'b1, 0);
        do_reset("midreset");
        step("post_reset", 1'b1, $urandom_range(0, MODV - 1));

        // Fault followed by 110, 111
        do_reset("reset6");
        step("rs0", 1'b1, 0);
        step("rs1", 1'b1, 3);
        step("rs2", 1'b1, 6);
        step("rs3", 1'b1, 7);

        // Random walk with mostly legal steps, gaps, garbage and occasional resets
        do_reset("reset7");
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                do_reset("rnd_reset");
            end else if (r < 20) begin
                step("rnd", 1'b0, $urandom_range(0, MODV - 1));
            end else begin
                if (r < 45)      g = bin2gray((m_bin + 1) % MODV);
                else if (r < 65) g = bin2gray((m_bin + MODV - 1) % MODV);
                else if (r < 75) g = bin2gray(m_bin);
                else             g = $urandom_range(0, MODV - 1);
                step("rnd", 1'b1, g);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
